pipelined_barrel_shifter: RTL and testbench
===========================================

# pipelined_barrel_shifter

Parametrised, fully pipelined barrel shifter with valid/ready handshake on both sides. It supports four shift modes: logical left, logical right, arithmetic right and rotate right. It also reports a carry-out (last bit shifted out), a zero flag and a user tag. It sits between an operand-issue stage and a result writeback stage, and sustains one operation per cycle under backpressure.

## Interface
- DATA_W, default 32: operand width; must be a power of two, at least 4. NUM_STAGE = log2(DATA_W).
- TAG_W, default 4: width of the opaque sideband tag carried alongside each operation.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  input operation valid.
- s_ready  output  1  block can accept an input operation this cycle.
- s_data  input  DATA_W  operand.
- s_amt  input  NUM_STAGE  shift amount, 0..DATA_W-1.
- s_mode  input  2  operation select: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- s_tag  input  TAG_W  sideband tag; returned unchanged.
- m_valid  output  1  result valid.
- m_ready  input  1  downstream accepts the result.
- m_data  output  DATA_W  shifted result.
- m_carry  output  1  last bit shifted out (see Operation).
- m_zero  output  1  asserted when m_data == 0.
- m_tag  output  TAG_W  tag of the operation currently on m_data.

## Operation
- Pipeline has NUM_STAGE registered stages. Stage k (k = 0..NUM_STAGE-1) applies a shift of 2^k in the captured mode when amt[k] = 1, and passes its value through otherwise.
- Each stage register holds: valid, data, amt, mode, tag and carry. The final stage register drives the m_* outputs directly.
- Modes:
  - LSL: zero-fill from the LSB.
  - LSR: zero-fill from the MSB.
  - ASR: fill from the MSB with s_data[DATA_W-1], the original sign bit.
  - ROR: bits leaving the LSB re-enter at the MSB.
- Carry, computed from the original operand and amount:
  - amt = 0: carry = 0 in all modes.
  - LSL: carry = s_data[DATA_W-amt].
  - LSR and ASR: carry = s_data[amt-1].
  - ROR: carry = result[DATA_W-1].
- m_zero is computed on the final result, either in the last stage or combinationally from the m_data register.
- Handshake:
  - Define ready_k = !valid_k || ready_(k+1), with ready_NUM_STAGE = m_ready. Stage k loads from stage k-1 (or from the input for k = 0) when ready_k is 1.
  - s_ready = ready_0, gated to 0 while rst = 1.
  - An operation transfers on the input when s_valid && s_ready; it leaves on the output when m_valid && m_ready.
  - Bubbles collapse: an empty stage accepts new data even if downstream is stalled.
- Ordering: results leave strictly in acceptance order. No operation is dropped or duplicated.

## Timing
- Latency: an operation accepted at rising edge t presents m_valid = 1 after edge t+NUM_STAGE-1, i.e. NUM_STAGE cycles of registered delay. With DATA_W = 8 this is 3 cycles.
- Throughput: 1 operation per cycle while m_ready = 1.
- Stall: while m_valid && !m_ready, m_data, m_carry, m_zero and m_tag stay stable.
- Full: with m_ready held low, the pipeline holds NUM_STAGE operations, after which s_ready = 0.
- Simultaneous events: when the pipeline is full and m_ready rises, s_ready rises in the same cycle. An output transfer and an input transfer then occur on the same edge.
- Reset:
  - On any edge with rst = 1, all stage valid bits clear. m_valid, m_data, m_carry and m_tag go to 0.
  - m_zero reads 1, because m_data = 0.
  - Operations in flight are discarded. Any s_valid presented during reset is not accepted.
  - s_ready = 1 on the first cycle after rst deasserts.
- s_amt and s_mode are sampled only on the accepting edge. Later changes on the input do not affect in-flight operations.

## Test plan
- LSL, DATA_W=8, s_data=0x96, amt=3, m_ready=1 -> after 3 cycles m_data=0xB0, m_carry=0, m_zero=0.
- LSR, ASR and ROR, DATA_W=8, s_data=0x96, amt=3:
  - LSR -> 0x12, carry 1.
  - ASR -> 0xF2, carry 1.
  - ROR -> 0xD2, carry 1.
  - Edge case: amt=0 in any mode -> 0x96, carry 0.
  - Edge case: LSR with s_data=0x01, amt=1 -> 0x00, carry 1, m_zero 1.
- Back-to-back stream: 100 random operations, m_ready=1, tags 0..15 cycling -> one result per cycle after 3-cycle fill, in order, each matching the reference model and its tag.
- Backpressure: hold m_ready=0 while driving s_valid=1 -> exactly 3 accepts, then s_ready=0 and the outputs hold. Release m_ready -> an input accept occurs on the same edge as the output transfer, and no loss or duplication across 200 random-stall cycles.
- Bubble collapse: accept op A, idle 2 cycles, accept op B, with m_ready=0 until both are queued -> both held, A emitted before B.
- Reset mid-stream: assert rst for 1 cycle with 3 operations in flight -> m_valid=0 and m_data=0 on the next cycle, none of the 3 operations ever emitted, and s_ready=1 after release.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter (LSL/LSR/ASR/ROR) with carry-out, zero flag and tag.
// Stage g shifts by 2**g when its amount bit is set; valid/ready handshake on both sides.
module pipelined_barrel_shifter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  localparam int NUM_STAGE = $clog2(DATA_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  input  logic [NUM_STAGE-1:0] s_amt,
  input  logic [1:0]           s_mode,
  input  logic [TAG_W-1:0]     s_tag,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_W-1:0]    m_data,
  output logic                 m_carry,
  output logic                 m_zero,
  output logic [TAG_W-1:0]     m_tag
);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;

  logic [NUM_STAGE:0]   stage_ready;
  logic [NUM_STAGE-1:0] stage_valid;

  // A stage may load when it is empty or its successor is loading too, so bubbles collapse.
  always_comb begin
    stage_ready[NUM_STAGE] = m_ready;
    for (int i = NUM_STAGE - 1; i >= 0; i--) begin
      stage_ready[i] = !stage_valid[i] || stage_ready[i+1];
    end
  end

  assign s_ready = stage_ready[0] && !rst;

  genvar g;
  generate
    for (g = 0; g < NUM_STAGE; g++) begin : g_stage
      localparam int SHIFT = 1 << g;
      localparam int AMT_W = NUM_STAGE - g;

      logic              in_valid;
      logic [DATA_W-1:0] in_data;
      logic [AMT_W-1:0]  in_amt;
      logic [1:0]        in_mode;
      logic [TAG_W-1:0]  in_tag;
      logic              in_carry;

      logic [DATA_W-1:0] next_data;
      logic              next_carry;

      logic              valid_q;
      logic [DATA_W-1:0] data_q;
      logic [TAG_W-1:0]  tag_q;
      logic              carry_q;

      if (g == 0) begin : g_src
        assign in_valid = s_valid && s_ready;
        assign in_data  = s_data;
        assign in_amt   = s_amt;
        assign in_mode  = s_mode;
        assign in_tag   = s_tag;
        assign in_carry = 1'b0;
      end else begin : g_src
        assign in_valid = g_stage[g-1].valid_q;
        assign in_data  = g_stage[g-1].data_q;
        assign in_amt   = g_stage[g-1].g_fwd.amt_q;
        assign in_mode  = g_stage[g-1].g_fwd.mode_q;
        assign in_tag   = g_stage[g-1].tag_q;
        assign in_carry = g_stage[g-1].carry_q;
      end

      // Carry is the last bit shifted out by the most recent active stage; with ASR the
      // MSB never changes, so filling from the current MSB equals filling from the original sign.
      always_comb begin
        next_data  = in_data;
        next_carry = in_carry;
        if (in_amt[0]) begin
          case (in_mode)
            MODE_LSL: begin
              next_data  = in_data << SHIFT;
              next_carry = in_data[DATA_W-SHIFT];
            end
            MODE_LSR: begin
              next_data  = in_data >> SHIFT;
              next_carry = in_data[SHIFT-1];
            end
            MODE_ASR: begin
              next_data  = $unsigned($signed(in_data) >>> SHIFT);
              next_carry = in_data[SHIFT-1];
            end
            default: begin
              next_data  = (in_data >> SHIFT) | (in_data << (DATA_W - SHIFT));
              next_carry = in_data[SHIFT-1];
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          tag_q   <= '0;
          carry_q <= 1'b0;
        end else if (stage_ready[g]) begin
          valid_q <= in_valid;
          if (in_valid) begin
            data_q  <= next_data;
            tag_q   <= in_tag;
            carry_q <= next_carry;
          end
        end
      end

      // Amount bits retire as they are consumed; the last stage needs neither amount nor mode.
      if (g < NUM_STAGE - 1) begin : g_fwd
        logic [AMT_W-2:0] amt_q;
        logic [1:0]       mode_q;

        always_ff @(posedge clk) begin
          if (rst) begin
            amt_q  <= '0;
            mode_q <= '0;
          end else if (stage_ready[g] && in_valid) begin
            amt_q  <= in_amt[AMT_W-1:1];
            mode_q <= in_mode;
          end
        end
      end

      assign stage_valid[g] = valid_q;
    end
  endgenerate

  assign m_valid = g_stage[NUM_STAGE-1].valid_q;
  assign m_data  = g_stage[NUM_STAGE-1].data_q;
  assign m_carry = g_stage[NUM_STAGE-1].carry_q;
  assign m_tag   = g_stage[NUM_STAGE-1].tag_q;
  assign m_zero  = (m_data == '0);

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter at DATA_W=8: driver pushes expected
// results, an independent monitor pops and compares on every output transfer.
module tb_pipelined_barrel_shifter;
  localparam int W  = 8;
  localparam int NS = 3;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic [NS-1:0] s_amt;
  logic [1:0]    s_mode;
  logic [TW-1:0] s_tag;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_carry;
  logic          m_zero;
  logic [TW-1:0] m_tag;

  pipelined_barrel_shifter #(.DATA_W(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_amt(s_amt),
    .s_mode(s_mode), .s_tag(s_tag),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_carry(m_carry),
    .m_zero(m_zero), .m_tag(m_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic          carry;
    logic          zero;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   mready_mode = 0;

  localparam logic [1:0]   DIR_MODE [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
  localparam logic [W-1:0] DIR_DATA [8] = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h01};
  localparam int           DIR_AMT  [8] = '{3, 3, 3, 0, 0, 0, 0, 1};
  localparam logic [W-1:0] DIR_RES  [8] = '{8'h12, 8'hF2, 8'hD2, 8'h96, 8'h96, 8'h96, 8'h96, 8'h00};
  localparam logic         DIR_CAR  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Bit-by-bit reference: result bit i is picked from the source position the mode names.
  function automatic void refModel(input logic [W-1:0] d, input int amt, input logic [1:0] mode,
                                   output logic [W-1:0] res, output logic carry);
    for (int i = 0; i < W; i++) begin
      case (mode)
        2'd0: if (i >= amt) res[i] = d[i-amt]; else res[i] = 1'b0;
        2'd1: if (i + amt < W) res[i] = d[i+amt]; else res[i] = 1'b0;
        2'd2: if (i + amt < W) res[i] = d[i+amt]; else res[i] = d[W-1];
        default: res[i] = d[(i+amt)%W];
      endcase
    end
    if (amt == 0) carry = 1'b0;
    else if (mode == 2'd0) carry = d[W-amt];
    else if (mode == 2'd3) carry = res[W-1];
    else carry = d[amt-1];
  endfunction

  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input int amt,
                               input logic [1:0] mode, input logic [TW-1:0] tag,
                               input logic [W-1:0] exp_d, input logic exp_c,
                               output logic accepted);
    @(negedge clk);
    s_valid = v;
    s_data  = d;
    s_amt   = amt[NS-1:0];
    s_mode  = mode;
    s_tag   = tag;
    #2;
    accepted = v && s_ready;
    if (accepted) exp_q.push_back('{data: exp_d, carry: exp_c, zero: (exp_d == '0), tag: tag});
  endtask

  task automatic sendOp(input logic v, input logic [W-1:0] d, input int amt,
                        input logic [1:0] mode, input logic [TW-1:0] tag, output logic acc);
    logic [W-1:0] r;
    logic         c;
    refModel(d, amt, mode, r, c);
    applyStimulus(v, d, amt, mode, tag, r, c, acc);
  endtask

  task automatic randOp(input logic v, input logic [TW-1:0] tag, output logic acc);
    sendOp(v, W'($urandom), int'($urandom_range(0, W-1)), 2'($urandom_range(0, 3)), tag, acc);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 0, 2'd0, '0, '0, 1'b0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1);
    checkOutput("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: drives m_ready, compares every output transfer, and checks stability while stalled.
  initial begin
    exp_t          e;
    logic [W-1:0]  held_d;
    logic          held_c;
    logic          held_z;
    logic [TW-1:0] held_t;
    logic          stalled;
    stalled = 1'b0;
    m_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (mready_mode == 0) m_ready = 1'b1;
      else if (mready_mode == 1) m_ready = 1'b0;
      else m_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled) begin
        checkOutput("stall_valid", m_valid, 1);
        checkOutput("stall_data", m_data, held_d);
        checkOutput("stall_carry", m_carry, held_c);
        checkOutput("stall_zero", m_zero, held_z);
        checkOutput("stall_tag", m_tag, held_t);
      end
      stalled = 1'b0;
      if (!rst && m_valid) begin
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_output: got data %0h tag %0h expected no output", m_data, m_tag);
          end else begin
            e = exp_q.pop_front();
            checkOutput("out_data", m_data, e.data);
            checkOutput("out_carry", m_carry, e.carry);
            checkOutput("out_zero", m_zero, e.zero);
            checkOutput("out_tag", m_tag, e.tag);
          end
        end else begin
          stalled = 1'b1;
          held_d  = m_data;
          held_c  = m_carry;
          held_z  = m_zero;
          held_t  = m_tag;
        end
      end
      #3;
      if (rst) begin
        exp_q.delete();
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic acc;
    int   lat;
    int   n;
    logic [TW-1:0] tag_a;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_amt = '0;
    s_mode = '0;
    s_tag = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("reset_m_valid", m_valid, 0);
    checkOutput("reset_m_data", m_data, 0);
    checkOutput("reset_m_carry", m_carry, 0);
    checkOutput("reset_m_zero", m_zero, 1);
    checkOutput("reset_m_tag", m_tag, 0);
    checkOutput("reset_s_ready", s_ready, 1);

    // LSL example with latency measurement
    applyStimulus(1'b1, 8'h96, 3, 2'd0, 4'd1, 8'hB0, 1'b0, acc);
    checkOutput("lsl_accept", acc, 1);
    lat = 0;
    do begin
      @(negedge clk);
      s_valid = 1'b0;
      lat++;
      #1;
    end while (!m_valid && lat < 10);
    checkOutput("latency", lat, 3);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, DIR_DATA[i], DIR_AMT[i], DIR_MODE[i], TW'(i + 2), DIR_RES[i], DIR_CAR[i], acc);
      checkOutput("directed_accept", acc, 1);
    end
    drain();

    // Back-to-back random stream, tags cycling
    for (int i = 0; i < 100; i++) begin
      randOp(1'b1, TW'(i % 16), acc);
      checkOutput("stream_accept", acc, 1);
    end
    drain();

    // Fill with m_ready low, then release with a simultaneous accept
    mready_mode = 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      randOp(1'b1, TW'(i), acc);
      if (acc) n++;
    end
    checkOutput("full_accepts", n, 3);
    checkOutput("full_s_ready", s_ready, 0);
    mready_mode = 0;
    randOp(1'b1, 4'd9, acc);
    checkOutput("simul_accept", acc, 1);

    mready_mode = 2;
    for (int i = 0; i < 200; i++) randOp(1'($urandom_range(0, 1)), TW'(i), acc);
    mready_mode = 0;
    drain();

    // Bubble collapse: A, two idle cycles, B, all while stalled
    mready_mode = 1;
    idle(1);
    tag_a = 4'd5;
    randOp(1'b1, tag_a, acc);
    checkOutput("bubble_accept_a", acc, 1);
    idle(2);
    randOp(1'b1, 4'd6, acc);
    checkOutput("bubble_accept_b", acc, 1);
    idle(4);
    checkOutput("bubble_hold_valid", m_valid, 1);
    checkOutput("bubble_head_tag", m_tag, tag_a);
    checkOutput("bubble_queued", exp_q.size(), 2);
    mready_mode = 0;
    drain();

    // Reset with three operations in flight and s_valid asserted during reset
    mready_mode = 1;
    idle(1);
    for (int i = 0; i < 3; i++) begin
      randOp(1'b1, TW'(10 + i), acc);
      checkOutput("inflight_accept", acc, 1);
    end
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h5A;
    #2;
    checkOutput("rst_s_ready", s_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b0;
    #2;
    checkOutput("midrst_m_valid", m_valid, 0);
    checkOutput("midrst_m_data", m_data, 0);
    checkOutput("midrst_m_zero", m_zero, 1);
    checkOutput("midrst_s_ready", s_ready, 1);
    mready_mode = 0;
    for (int i = 0; i < 20; i++) begin
      randOp(1'b1, TW'(i), acc);
      checkOutput("post_rst_accept", acc, 1);
    end
    drain();
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
